conv_zbuf: RTL and testbench

CONV_ZBUF -- requirements
Module: conv_zbuf

---
 rtl/conv_zbuf_if.sv | 53 +++++
 rtl/conv_zbuf.sv | 196 +++++++++++++++++++
 tb/tb_conv_zbuf.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_zbuf_if.sv
// conv_zbuf_if -- bundle of every conv_zbuf signal except clock and reset.
//
// Parameters:
//   DATA_W  width of a result word
//   ADDR_W  result address width (buffer depth is 2**ADDR_W)
//
// Signals (direction seen from the buffer, i.e. the slave modport):
//   cap_start  in   arm capture of a new convolution result (pulse)
//   abort      in   return to IDLE from any state (pulse)
//   writeZ     in   result write strobe from the convolution core
//   memZ_addr  in   result write address
//   dataZ      in   result write data
//   conv_done  in   completion pulse from the convolution core
//   out_data   out  drained result word
//   out_valid  out  out_data is valid
//   out_ready  in   consumer accepts out_data
//   out_last   out  current word is the final word
//   zlen       out  number of captured words (highest written address + 1)
//   busy       out  high while capturing or draining
//   drain_done out  one-cycle pulse when the final word is accepted
//   err        out  sticky flag: writeZ seen outside CAPTURE
//
// The master modport is the producer/consumer side (core + sink);
// the slave modport is the buffer itself.
interface conv_zbuf_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6
);
   logic              cap_start;
   logic              abort;
   logic              writeZ;
   logic [ADDR_W-1:0] memZ_addr;
   logic [DATA_W-1:0] dataZ;
   logic              conv_done;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [ADDR_W:0]   zlen;
   logic              busy;
   logic              drain_done;
   logic              err;

   modport master (
      output cap_start, abort, writeZ, memZ_addr, dataZ, conv_done, out_ready,
      input  out_data, out_valid, out_last, zlen, busy, drain_done, err
   );

   modport slave (
      input  cap_start, abort, writeZ, memZ_addr, dataZ, conv_done, out_ready,
      output out_data, out_valid, out_last, zlen, busy, drain_done, err
   );
endinterface

// File: rtl/conv_zbuf.sv
// conv_zbuf -- capture buffer for convolution results.
//
// The convolution core writes result words at arbitrary addresses while the
// buffer is in CAPTURE. On conv_done the buffer drains entries
// 0 .. zlen-1 over a valid/ready stream, one word per cycle, flagging the
// final word with out_last and pulsing drain_done when it is accepted.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   zb     conv_zbuf_if.slave carrying the capture, stream and status signals
//
// Optional feature (macro ZBUF_ZERO_FILL_EN):
//   when defined, reset and entry into CAPTURE clear every entry to 0 so that
//   unwritten holes drain as 0. When undefined, the storage is a plain RAM
//   and holes drain whatever the entry held before.
module conv_zbuf #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   conv_zbuf_if.slave  zb
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
   localparam logic [ADDR_W:0]   ONE_Z = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]   TWO_Z = (ADDR_W + 1)'(2);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   state_t            state_reg;
   logic [ADDR_W:0]   zlen_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic              out_valid_reg;
   logic              out_last_reg;
   logic              busy_reg;
   logic              drain_done_reg;
   logic              err_reg;
   logic [DATA_W-1:0] out_data_reg;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_en;
   logic [ADDR_W:0]   wr_len;
   logic [ADDR_W:0]   zlen_cap;
   logic [ADDR_W-1:0] rd_addr_next;
   logic              last_next_hit;

   // A capture write is blocked by reset and by abort, which outrank
   // every other input.
   assign wr_en  = rst_n && !zb.abort && (state_reg == CAPTURE) && zb.writeZ;
   assign wr_len = {1'b0, zb.memZ_addr} + ONE_Z;

   // Length after this cycle's write, so a write coinciding with conv_done
   // is counted before the drain starts.
   assign zlen_cap = (wr_en && (wr_len > zlen_reg)) ? wr_len : zlen_reg;

   // The word after rd_ptr is the last one when rd_ptr + 2 == zlen.
   assign last_next_hit = (({1'b0, rd_ptr_reg} + TWO_Z) == zlen_reg);

   // Address the read port must present next cycle. The read is registered,
   // so the pointer is looked ahead by one edge.
   always_comb begin
      rd_addr_next = rd_ptr_reg;
      if ((state_reg == CAPTURE) && zb.conv_done) begin
         rd_addr_next = '0;
      end else if ((state_reg == DRAIN) && zb.out_ready && !out_last_reg) begin
         rd_addr_next = rd_ptr_reg + ONE_A;
      end
   end

   // Control state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         zlen_reg       <= '0;
         rd_ptr_reg     <= '0;
         out_valid_reg  <= 1'b0;
         out_last_reg   <= 1'b0;
         busy_reg       <= 1'b0;
         drain_done_reg <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         drain_done_reg <= 1'b0;
         if (zb.abort) begin
            // zlen is intentionally kept so software can inspect it.
            state_reg     <= IDLE;
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (zb.writeZ) begin
                     err_reg <= 1'b1;
                  end
                  // Arming clears err even if a stray write arrives alongside.
                  if (zb.cap_start) begin
                     state_reg <= CAPTURE;
                     zlen_reg  <= '0;
                     err_reg   <= 1'b0;
                     busy_reg  <= 1'b1;
                  end
               end
               CAPTURE: begin
                  zlen_reg <= zlen_cap;
                  if (zb.conv_done) begin
                     rd_ptr_reg <= '0;
                     if (zlen_cap != '0) begin
                        state_reg     <= DRAIN;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= (zlen_cap == ONE_Z);
                     end else begin
                        // Nothing captured: finish without streaming.
                        state_reg      <= IDLE;
                        busy_reg       <= 1'b0;
                        drain_done_reg <= 1'b1;
                     end
                  end
               end
               DRAIN: begin
                  if (zb.writeZ) begin
                     err_reg <= 1'b1;
                  end
                  if (zb.out_ready) begin
                     if (out_last_reg) begin
                        state_reg      <= IDLE;
                        out_valid_reg  <= 1'b0;
                        out_last_reg   <= 1'b0;
                        busy_reg       <= 1'b0;
                        drain_done_reg <= 1'b1;
                     end else begin
                        rd_ptr_reg   <= rd_ptr_reg + ONE_A;
                        out_last_reg <= last_next_hit;
                     end
                  end
               end
               default: begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  out_last_reg  <= 1'b0;
                  busy_reg      <= 1'b0;
               end
            endcase
         end
      end
   end

   // Storage write port.
`ifdef ZBUF_ZERO_FILL_EN
   logic clear_en;
   assign clear_en = !zb.abort && (state_reg == IDLE) && zb.cap_start;

   always_ff @(posedge clk) begin
      if (!rst_n || clear_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[zb.memZ_addr] <= zb.dataZ;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[zb.memZ_addr] <= zb.dataZ;
      end
   end
`endif

   // Registered read port. The bypass covers a write landing on the entry
   // being fetched in the same cycle (write together with conv_done at
   // address 0). While stalled the same address is re-read, and no writes
   // occur during DRAIN, so out_data stays stable.
   always_ff @(posedge clk) begin
      if (wr_en && (zb.memZ_addr == rd_addr_next)) begin
         out_data_reg <= zb.dataZ;
      end else begin
         out_data_reg <= mem[rd_addr_next];
      end
   end

   assign zb.out_data   = out_data_reg;
   assign zb.out_valid  = out_valid_reg;
   assign zb.out_last   = out_last_reg;
   assign zb.zlen       = zlen_reg;
   assign zb.busy       = busy_reg;
   assign zb.drain_done = drain_done_reg;
   assign zb.err        = err_reg;
endmodule

// File: tb/tb_conv_zbuf.sv
// tb_conv_zbuf -- scoreboard bench for conv_zbuf.
// Stimulus pushes expected output words into a queue; a monitor on the
// falling edge compares every presented word against the queue head and
// pops it on a handshake. Status outputs are checked directly by the
// stimulus process.
module tb_conv_zbuf;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 6;

`ifdef ZBUF_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } exp_t;

   logic clk;
   logic rst_n;

   conv_zbuf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) zb ();

   conv_zbuf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .zb    (zb.slave)
   );

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   dd_count = 0;
   int   valid_cycles = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endfunction

   // Holes read 0 when zero-fill is built in, otherwise the stale value.
   function automatic logic [DATA_W-1:0] hole(logic [DATA_W-1:0] stale);
      return ZF ? '0 : stale;
   endfunction

   // Monitor: compare presented words against the scoreboard.
   always @(negedge clk) begin
      if (zb.drain_done === 1'b1) dd_count++;
      if (zb.out_valid === 1'b1) begin
         valid_cycles++;
         if (exp_q.size() > 0) begin
            check("out_data", 64'(zb.out_data), 64'(exp_q[0].data));
            check("out_last", 64'(zb.out_last), 64'(exp_q[0].last));
            if (zb.out_ready === 1'b1) begin
               $display("word 0x%0h last=%0b accepted", zb.out_data, zb.out_last);
               void'(exp_q.pop_front());
            end
         end else if (zb.out_ready === 1'b1) begin
            check("unexpected_word", 64'(zb.out_data), 64'hFFFF_FFFF_FFFF_FFFF);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(logic [DATA_W-1:0] d, logic l);
      exp_t e;
      e.data = d;
      e.last = l;
      exp_q.push_back(e);
   endtask

   task automatic start_cap();
      zb.cap_start = 1'b1;
      tick();
      zb.cap_start = 1'b0;
   endtask

   task automatic wr(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic done);
      zb.writeZ    = 1'b1;
      zb.memZ_addr = a;
      zb.dataZ     = d;
      zb.conv_done = done;
      tick();
      zb.writeZ    = 1'b0;
      zb.conv_done = 1'b0;
   endtask

   task automatic finish_cap();
      zb.conv_done = 1'b1;
      tick();
      zb.conv_done = 1'b0;
   endtask

   // Drain until the scoreboard empties. mode 1 uses a 1,0,0,1 ready pattern
   // and injects a stray write to address 4 early in the drain.
   task automatic drain(int mode);
      int pat[4];
      bit done;
      pat = '{1, 0, 0, 1};
      done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         zb.out_ready = (mode == 1) ? pat[i % 4][0] : 1'b1;
         if (mode == 1 && i == 1) begin
            zb.writeZ    = 1'b1;
            zb.memZ_addr = 6'd4;
            zb.dataZ     = 32'h0000_0BAD;
         end else begin
            zb.writeZ = 1'b0;
         end
         tick();
      end
      zb.writeZ    = 1'b0;
      zb.out_ready = 1'b0;
      check("drain_complete", 64'(done), 64'd1);
      tick();
      tick();
   endtask

   initial begin
      int dd0;
      int vc0;
      rst_n        = 1'b0;
      zb.cap_start = 1'b0;
      zb.abort     = 1'b0;
      zb.writeZ    = 1'b0;
      zb.memZ_addr = '0;
      zb.dataZ     = '0;
      zb.conv_done = 1'b0;
      zb.out_ready = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_out_valid", 64'(zb.out_valid), 64'd0);
      check("rst_out_last", 64'(zb.out_last), 64'd0);
      check("rst_busy", 64'(zb.busy), 64'd0);
      check("rst_drain_done", 64'(zb.drain_done), 64'd0);
      check("rst_err", 64'(zb.err), 64'd0);
      check("rst_zlen", 64'(zb.zlen), 64'd0);
      rst_n = 1'b1;
      tick();

      // Preload 0..7 with 0x100+i so later holes have known contents.
      start_cap();
      check("cap_busy", 64'(zb.busy), 64'd1);
      for (int i = 0; i < 8; i++) begin
         wr(6'(i), 32'h100 + 32'(i), 1'b0);
         push(32'h100 + 32'(i), i == 7);
      end
      dd0 = dd_count;
      finish_cap();
      check("pre_zlen", 64'(zb.zlen), 64'd8);
      drain(0);
      check("pre_drain_done", 64'(dd_count - dd0), 64'd1);

      // Basic capture 0..4 = 10..50, always ready.
      start_cap();
      for (int i = 0; i < 5; i++) begin
         wr(6'(i), 32'(10 * (i + 1)), 1'b0);
         push(32'(10 * (i + 1)), i == 4);
      end
      dd0 = dd_count;
      finish_cap();
      check("first_drain_valid", 64'(zb.out_valid), 64'd1);
      check("first_drain_busy", 64'(zb.busy), 64'd1);
      drain(0);
      check("s1_zlen", 64'(zb.zlen), 64'd5);
      check("s1_drain_done", 64'(dd_count - dd0), 64'd1);
      check("s1_idle_busy", 64'(zb.busy), 64'd0);
      check("s1_idle_valid", 64'(zb.out_valid), 64'd0);

      // Same capture with stalls and a stray write during DRAIN.
      start_cap();
      for (int i = 0; i < 5; i++) begin
         wr(6'(i), 32'(10 * (i + 1)), 1'b0);
         push(32'(10 * (i + 1)), i == 4);
      end
      dd0 = dd_count;
      finish_cap();
      drain(1);
      check("s2_drain_done", 64'(dd_count - dd0), 64'd1);
      check("s2_err_drain_write", 64'(zb.err), 64'd1);

      // Writes 0..2, then address 7 together with conv_done.
      start_cap();
      check("s3_err_cleared", 64'(zb.err), 64'd0);
      for (int i = 0; i < 3; i++) wr(6'(i), 32'(i + 1), 1'b0);
      push(32'd1, 1'b0);
      push(32'd2, 1'b0);
      push(32'd3, 1'b0);
      push(hole(32'd40), 1'b0);
      push(hole(32'd50), 1'b0);
      push(hole(32'h105), 1'b0);
      push(hole(32'h106), 1'b0);
      push(32'hAB, 1'b1);
      wr(6'd7, 32'hAB, 1'b1);
      check("s3_zlen", 64'(zb.zlen), 64'd8);
      drain(0);

      // Stray write in IDLE sets err, cap_start clears it, memory unchanged.
      wr(6'd1, 32'hDEAD, 1'b0);
      check("s4_err_set", 64'(zb.err), 64'd1);
      start_cap();
      check("s4_err_clr", 64'(zb.err), 64'd0);
      push(hole(32'd1), 1'b0);
      push(hole(32'd2), 1'b0);
      push(32'h33, 1'b1);
      wr(6'd2, 32'h33, 1'b0);
      finish_cap();
      drain(0);

      // conv_done with no writes.
      start_cap();
      dd0 = dd_count;
      vc0 = valid_cycles;
      finish_cap();
      tick();
      tick();
      check("s5_drain_done", 64'(dd_count - dd0), 64'd1);
      check("s5_no_valid", 64'(valid_cycles - vc0), 64'd0);
      check("s5_zlen", 64'(zb.zlen), 64'd0);
      check("s5_busy", 64'(zb.busy), 64'd0);

      // Address 63 saturates zlen at 64; abort in CAPTURE keeps it.
      start_cap();
      wr(6'd63, 32'h63, 1'b0);
      wr(6'd5, 32'h55, 1'b0);
      check("s6_zlen_sat", 64'(zb.zlen), 64'd64);
      zb.abort = 1'b1;
      tick();
      zb.abort = 1'b0;
      check("s6_abort_busy", 64'(zb.busy), 64'd0);
      check("s6_abort_zlen", 64'(zb.zlen), 64'd64);

      // Abort mid-DRAIN after two words.
      start_cap();
      for (int i = 0; i < 5; i++) wr(6'(i), 32'(10 * (i + 1)), 1'b0);
      push(32'd10, 1'b0);
      push(32'd20, 1'b0);
      dd0 = dd_count;
      finish_cap();
      zb.out_ready = 1'b1;
      tick();
      tick();
      zb.out_ready = 1'b0;
      zb.abort     = 1'b1;
      tick();
      zb.abort = 1'b0;
      check("s7_abort_valid", 64'(zb.out_valid), 64'd0);
      check("s7_abort_busy", 64'(zb.busy), 64'd0);
      check("s7_abort_zlen", 64'(zb.zlen), 64'd5);
      tick();
      check("s7_abort_no_dd", 64'(dd_count - dd0), 64'd0);
      check("s7_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset mid-DRAIN after two words.
      start_cap();
      for (int i = 0; i < 5; i++) wr(6'(i), 32'(10 * (i + 1)), 1'b0);
      push(32'd10, 1'b0);
      push(32'd20, 1'b0);
      finish_cap();
      zb.out_ready = 1'b1;
      tick();
      tick();
      zb.out_ready = 1'b0;
      zb.abort     = 1'b1;
      rst_n        = 1'b0;
      tick();
      zb.abort = 1'b0;
      rst_n    = 1'b1;
      check("s8_rst_valid", 64'(zb.out_valid), 64'd0);
      check("s8_rst_last", 64'(zb.out_last), 64'd0);
      check("s8_rst_busy", 64'(zb.busy), 64'd0);
      check("s8_rst_zlen", 64'(zb.zlen), 64'd0);
      check("s8_queue_empty", 64'(exp_q.size()), 64'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
      $fatal(1, "watchdog");
   end
endmodule
